// File: rtl/key_link_pkg.sv
// Shared frame definition for the button-to-key serial link (sender and receiver).
// Frame: start(0), d0..d2 LSB first, even parity, stop(1).
package key_link_pkg;

    localparam int KEY_W                = 3;
    localparam int FRAME_DATA_BITS      = 3;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Parity bit that makes d0^d1^d2^P equal to zero.
    function automatic logic even_parity(input logic [KEY_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/key_link_bit_timer.sv
// Bit-period counter for the key link receiver.
// Flags half_tick at count CLKS_PER_BIT/2-1 and full_tick at CLKS_PER_BIT-1, then wraps.
module key_link_bit_timer
    import key_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == FULL_CNT) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign half_tick = (count == HALF_CNT);
    assign full_tick = (count == FULL_CNT);

endmodule

// File: rtl/key_link_rx.sv
// Receive end of the button-to-key link: recovers 3-bit key codes from Rx frames.
// Optional RX_MAJORITY_VOTE_EN: every bit decided by 2-of-3 vote around mid-bit.
module key_link_rx
    import key_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rx,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    logic rx_meta;
    logic rs;
    logic level;
    logic level_prev;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rs         <= 1'b1;
            level_prev <= 1'b1;
        end else begin
            rx_meta    <= Rx;
            rs         <= rx_meta;
            level_prev <= level;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    // Vote over three consecutive rs samples; the decision lags rs by one cycle,
    // which shifts every sample point (start edge included) by one cycle.
    logic [1:0] rs_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_hist <= 2'b11;
        end else begin
            rs_hist <= {rs_hist[0], rs};
        end
    end

    assign level = (rs_hist[1] & rs_hist[0]) | (rs_hist[1] & rs) | (rs_hist[0] & rs);
`else
    assign level = rs;
`endif

    assign fall = level_prev & ~level;

    rx_state_e        state;
    rx_state_e        state_next;
    logic [1:0]       bit_idx;
    logic [1:0]       bit_idx_next;
    logic [KEY_W-1:0] data;
    logic             par_bit;
    logic             timer_clear;
    logic             half_tick;
    logic             full_tick;
    logic             sample_data;
    logic             sample_parity;
    logic             set_valid;
    logic             set_perr;
    logic             set_ferr;

    key_link_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_comb begin
        state_next    = state;
        bit_idx_next  = bit_idx;
        timer_clear   = 1'b0;
        sample_data   = 1'b0;
        sample_parity = 1'b0;
        set_valid     = 1'b0;
        set_perr      = 1'b0;
        set_ferr      = 1'b0;

        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (fall) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_tick) begin
                    if (level) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        timer_clear  = 1'b1;
                        bit_idx_next = 2'd0;
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    sample_data = 1'b1;
                    if (bit_idx == 2'(FRAME_DATA_BITS - 1)) begin
                        state_next = PARITY;
                    end else begin
                        bit_idx_next = bit_idx + 2'd1;
                    end
                end
            end
            PARITY: begin
                if (full_tick) begin
                    sample_parity = 1'b1;
                    state_next    = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    state_next = IDLE;
                    // A bad stop bit masks any parity problem in the same frame.
                    if (!level) begin
                        set_ferr = 1'b1;
                    end else if (even_parity(data) != par_bit) begin
                        set_perr = 1'b1;
                    end else begin
                        set_valid = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= 2'd0;
            data       <= '0;
            par_bit    <= 1'b0;
            key        <= '0;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            if (sample_data) begin
                data[bit_idx] <= level;
            end
            if (sample_parity) begin
                par_bit <= level;
            end
            if (set_valid) begin
                key <= data;
            end
            key_valid  <= set_valid;
            parity_err <= set_perr;
            frame_err  <= set_ferr;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_link_rx.sv
// Self-checking bench for key_link_rx: table of frames plus hand-written corner sequences.
// Honours RX_MAJORITY_VOTE_EN for latency and glitch expectations.
module tb_key_link_rx;
    import key_link_pkg::*;

    localparam int CLKS = 16;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int LAT = 92;
`else
    localparam int LAT = 91;
`endif
    localparam int EV_VALID = 0;
    localparam int EV_PERR  = 1;
    localparam int EV_FERR  = 2;
    localparam int NVEC     = 7;

    typedef struct {
        logic [2:0] key;
        int         kind;
    } exp_t;

    typedef struct {
        logic [2:0] data;
        logic       par;
        logic       stop;
        int         exp_kind;
        logic [2:0] exp_key;
    } vector_t;

    logic       clk;
    logic       rst;
    logic       Rx;
    logic [2:0] key;
    logic       key_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    key_link_rx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Rx        (Rx),
        .key       (key),
        .key_valid (key_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    exp_t    exp_q[$];
    exp_t    mon_exp;
    int      mon_kind;
    int      tests_run = 0;
    int      tests_failed = 0;
    int      cycle_cnt = 0;
    int      last_pulse_cycle = -1;
    int      valid_cycles = 0;
    vector_t vecs[NVEC];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (key_valid) valid_cycles++;
        if (key_valid || parity_err || frame_err) begin
            last_pulse_cycle = cycle_cnt;
            checkOutput("pulse_onehot", 32'($countones({key_valid, parity_err, frame_err})), 32'd1);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {29'd0, frame_err, parity_err, key_valid}, 32'd0);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_kind = frame_err ? EV_FERR : (parity_err ? EV_PERR : EV_VALID);
                checkOutput("pulse_kind", mon_kind, mon_exp.kind);
                checkOutput("pulse_key", {29'd0, key}, {29'd0, mon_exp.key});
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushExp(input int kind, input logic [2:0] k);
        exp_t e;
        e.kind = kind;
        e.key  = k;
        exp_q.push_back(e);
    endtask

    task automatic sendFrame(input logic [2:0] d, input logic p, input logic s);
        Rx = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 3; i++) begin
            Rx = d[i];
            if (i == 1) begin
                waitCycles(CLKS / 2);
                checkOutput("busy_mid_frame", {31'd0, busy}, 32'd1);
                waitCycles(CLKS / 2);
            end else begin
                waitCycles(CLKS);
            end
        end
        Rx = p;
        waitCycles(CLKS);
        Rx = s;
        waitCycles(CLKS);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            waitCycles(1);
            n++;
        end
        checkOutput("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic applyStimulus(input vector_t v);
        int start_cycle;
        start_cycle = cycle_cnt;
        pushExp(v.exp_kind, v.exp_key);
        sendFrame(v.data, v.par, v.stop);
        Rx = 1'b1;
        waitCycles(20);
        drain();
        checkOutput("latency", last_pulse_cycle - start_cycle, LAT);
        checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen_busy;
        vecs[0] = '{3'b101, 1'b0, 1'b1, EV_VALID, 3'b101};
        vecs[1] = '{3'b011, 1'b1, 1'b1, EV_PERR,  3'b101};
        vecs[2] = '{3'b000, 1'b0, 1'b1, EV_VALID, 3'b000};
        vecs[3] = '{3'b111, 1'b0, 1'b1, EV_PERR,  3'b000};
        vecs[4] = '{3'b111, 1'b1, 1'b0, EV_FERR,  3'b000};
        vecs[5] = '{3'b100, 1'b0, 1'b0, EV_FERR,  3'b000};
        vecs[6] = '{3'b011, 1'b0, 1'b1, EV_VALID, 3'b011};

        clk = 1'b0;
        rst = 1'b1;
        Rx  = 1'b1;
        waitCycles(3);
        checkOutput("reset_key", {29'd0, key}, 32'd0);
        checkOutput("reset_key_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        waitCycles(10);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Stop bit low, then the line stays low (break): exactly one frame_err.
        pushExp(EV_FERR, 3'b011);
        sendFrame(3'b110, 1'b0, 1'b0);
        waitCycles(40);
        checkOutput("busy_during_break", {31'd0, busy}, 32'd0);
        Rx = 1'b1;
        waitCycles(20);
        drain();
        pushExp(EV_VALID, 3'b010);
        sendFrame(3'b010, 1'b1, 1'b1);
        waitCycles(20);
        drain();
        checkOutput("key_after_break", {29'd0, key}, 32'h2);

        // Short low pulse on an idle line is a false start.
        Rx = 1'b0;
        waitCycles(4);
        Rx = 1'b1;
        waitCycles(1);
        checkOutput("false_start_busy", {31'd0, busy}, 32'd1);
        waitCycles(20);
        checkOutput("false_start_idle", {31'd0, busy}, 32'd0);

`ifdef RX_MAJORITY_VOTE_EN
        Rx = 1'b0;
        waitCycles(1);
        Rx = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 12; i++) begin
            waitCycles(1);
            if (busy) seen_busy = 1;
        end
        checkOutput("glitch_no_busy", seen_busy, 32'd0);
`endif

        // Back-to-back frames with no idle gap.
        pushExp(EV_VALID, 3'b001);
        pushExp(EV_VALID, 3'b111);
        sendFrame(3'b001, 1'b1, 1'b1);
        sendFrame(3'b111, 1'b1, 1'b1);
        waitCycles(20);
        drain();
        checkOutput("key_after_b2b", {29'd0, key}, 32'h7);

        // Reset in the middle of the data bits of 3'b100.
        Rx = 1'b0;
        waitCycles(CLKS);
        waitCycles(CLKS);
        waitCycles(CLKS / 2);
        checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        Rx  = 1'b1;
        waitCycles(1);
        checkOutput("midreset_key", {29'd0, key}, 32'd0);
        checkOutput("midreset_key_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("midreset_parity_err", {31'd0, parity_err}, 32'd0);
        checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        waitCycles(20);
        pushExp(EV_VALID, 3'b100);
        sendFrame(3'b100, 1'b1, 1'b1);
        waitCycles(20);
        drain();
        checkOutput("key_after_reset", {29'd0, key}, 32'h4);

        checkOutput("valid_pulse_cycles", valid_cycles, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
